mcm_filter_sequencer: RTL and testbench

MCM_FILTER_SEQUENCER -- requirements
Module: mcm_filter_sequencer

---
 rtl/mcm_filter_sequencer_if.sv | 31 +++
 rtl/mcm_filter_sequencer.sv | 121 ++++++++++++
 tb/tb_mcm_filter_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mcm_filter_sequencer_if.sv
// Port bundle for the MCM filter sequencer: run control, reference-buffer read,
// shared constant-multiplier operand/products and the predicted-sample stream.
interface mcm_filter_sequencer_if;
    logic               start;
    logic [4:0]         len;
    logic               ref_rd_en;
    logic [5:0]         ref_rd_addr;
    logic [7:0]         ref_data;
    logic [7:0]         mcm_x;
    logic signed [15:0] mcm_y1;
    logic signed [15:0] mcm_y2;
    logic signed [15:0] mcm_y3;
    logic signed [15:0] mcm_y4;
    logic               pred_valid;
    logic [7:0]         pred_data;
    logic [4:0]         pred_idx;
    logic               busy;
    logic               done;

    modport master (
        input  start, len, ref_data, mcm_y1, mcm_y2, mcm_y3, mcm_y4,
        output ref_rd_en, ref_rd_addr, mcm_x, pred_valid, pred_data, pred_idx,
        output busy, done
    );

    modport slave (
        output start, len, ref_data, mcm_y1, mcm_y2, mcm_y3, mcm_y4,
        input  ref_rd_en, ref_rd_addr, mcm_x, pred_valid, pred_data, pred_idx,
        input  busy, done
    );
endinterface

// File: rtl/mcm_filter_sequencer.sv
// 4-tap transposed FIR sequencer over a shared MCM block; MCM_FILTER_CLIP_EN selects clip vs wrap.
// Latency: start in cycle 0 -> pred[k] valid in cycle 6+k, done pulse in cycle L+6.
// No backpressure: output stream runs gap-free; start is ignored while busy.
module mcm_filter_sequencer #(
    parameter int MAX_LEN = 32,
    parameter int ACC_W   = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    mcm_filter_sequencer_if.master bus
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(32);
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(255);

    state_t state_q, state_d;

    logic [5:0] len_q;
    logic [5:0] addr_q;
    logic       dvld_q;
    logic [5:0] daddr_q;

    logic signed [ACC_W-1:0] s1_q, s2_q, s3_q;
    logic signed [ACC_W-1:0] y1e, y2e, y3e, y4e;
    logic signed [ACC_W-1:0] sum, rnd;
    logic [7:0]              r8;
    logic                    out_due;

    logic       pvld_q;
    logic [7:0] pdat_q;
    logic [4:0] pidx_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = FETCH;
            FETCH:   if (addr_q == len_q + 6'd2) state_d = DRAIN;
            DRAIN:   if (pvld_q && (pidx_q == 5'(len_q - 6'd1))) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.ref_rd_en   = (state_q == FETCH);
    assign bus.ref_rd_addr = (state_q == FETCH) ? addr_q : 6'd0;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.mcm_x       = dvld_q ? bus.ref_data : 8'd0;

    assign y1e = ACC_W'(bus.mcm_y1);
    assign y2e = ACC_W'(bus.mcm_y2);
    assign y3e = ACC_W'(bus.mcm_y3);
    assign y4e = ACC_W'(bus.mcm_y4);

    // With sample n on the multiplier this cycle, sum is pred[n-3].
    assign sum     = s3_q + y4e;
    assign rnd     = (sum + HALF) >>> 6;
    assign out_due = dvld_q && (daddr_q >= 6'd3);

`ifdef MCM_FILTER_CLIP_EN
    always_comb begin
        if (rnd < 0)
            r8 = 8'd0;
        else if (rnd > MAXV)
            r8 = 8'd255;
        else
            r8 = rnd[7:0];
    end
`else
    logic unused_rnd_hi;
    assign unused_rnd_hi = ^rnd[ACC_W-1:8];
    assign r8            = rnd[7:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= 6'd0;
            addr_q  <= 6'd0;
            dvld_q  <= 1'b0;
            daddr_q <= 6'd0;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            pvld_q  <= 1'b0;
            pdat_q  <= 8'd0;
            pidx_q  <= 5'd0;
        end else begin
            state_q <= state_d;
            dvld_q  <= (state_q == FETCH);
            daddr_q <= addr_q;

            if (state_q == IDLE && bus.start) begin
                len_q  <= (bus.len == 5'd0) ? 6'(MAX_LEN) : {1'b0, bus.len};
                addr_q <= 6'd0;
                s1_q   <= '0;
                s2_q   <= '0;
                s3_q   <= '0;
            end else begin
                if (state_q == FETCH)
                    addr_q <= addr_q + 6'd1;
                if (dvld_q) begin
                    s1_q <= y1e;
                    s2_q <= s1_q + y2e;
                    s3_q <= s2_q + y3e;
                end
            end

            pvld_q <= out_due;
            pdat_q <= out_due ? r8 : 8'd0;
            pidx_q <= out_due ? 5'(daddr_q - 6'd3) : 5'd0;
        end
    end

    assign bus.pred_valid = pvld_q;
    assign bus.pred_data  = pdat_q;
    assign bus.pred_idx   = pidx_q;

endmodule

// File: tb/tb_mcm_filter_sequencer.sv
// Bench for mcm_filter_sequencer with the c=(34,23,-3,7) multiplier block and a 1-cycle reference buffer.
// Expected samples and done pulses are queued at start time and matched as the DUT emits them.
module tb_mcm_filter_sequencer;

    typedef struct {
        int cyc;
        int idx;
        int dat;
    } exp_t;

    typedef struct {
        int cyc;
        int len;
    } done_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_bad;
    int   rd_cnt;

    logic [7:0] ref_mem [0:63];
    exp_t       exp_q[$];
    done_t      done_q[$];
    exp_t       e_mon;
    done_t      d_mon;

    mcm_filter_sequencer_if bus ();

    mcm_filter_sequencer #(.MAX_LEN(32), .ACC_W(18)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference buffer: data for an address appears one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (bus.ref_rd_en)
            bus.ref_data <= ref_mem[bus.ref_rd_addr];
        else
            bus.ref_data <= 8'h5A;
    end

    assign bus.mcm_y1 = 16'(int'(bus.mcm_x) * 34);
    assign bus.mcm_y2 = 16'(int'(bus.mcm_x) * 23);
    assign bus.mcm_y3 = 16'(int'(bus.mcm_x) * -3);
    assign bus.mcm_y4 = 16'(int'(bus.mcm_x) * 7);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model(input int k);
        int s;
        int r;
        s = 34 * int'(ref_mem[k]) + 23 * int'(ref_mem[k+1])
          - 3 * int'(ref_mem[k+2]) + 7 * int'(ref_mem[k+3]);
        r = (s + 32) >>> 6;
`ifdef MCM_FILTER_CLIP_EN
        if (r < 0)   r = 0;
        if (r > 255) r = 255;
`else
        r = r & 255;
`endif
        return r;
    endfunction

    // Monitor: every sample, done pulse and read strobe is matched against the queues.
    always @(negedge clk) begin
        if (bus.pred_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_pred", 1, 0);
            end else begin
                e_mon = exp_q.pop_front();
                check("pred_cycle", cyc, e_mon.cyc);
                check("pred_idx", bus.pred_idx, e_mon.idx);
                check("pred_data", bus.pred_data, e_mon.dat);
            end
        end else begin
            check("pred_idle_zero", {bus.pred_data, bus.pred_idx}, 0);
        end
        if (bus.ref_rd_en) begin
            check("rd_addr", bus.ref_rd_addr, rd_cnt);
            rd_cnt++;
        end
        if (bus.done) begin
            if (done_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                d_mon = done_q.pop_front();
                check("done_cycle", cyc, d_mon.cyc);
                check("rd_count", rd_cnt, d_mon.len + 3);
            end
        end
        if (!bus.busy)
            rd_cnt = 0;
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Call at a negedge; that cycle becomes cycle 0 of the run.
    task automatic start_run(input int len5, input bit use_const, input int cval, output int t0);
        int l;
        exp_t e;
        done_t d;
        l = (len5 == 0) ? 32 : len5;
        t0 = cyc;
        bus.start = 1'b1;
        bus.len   = 5'(len5);
        for (int k = 0; k < l; k++) begin
            e.cyc = t0 + 6 + k;
            e.idx = k;
            e.dat = use_const ? cval : model(k);
            exp_q.push_back(e);
        end
        d.cyc = t0 + l + 6;
        d.len = l;
        done_q.push_back(d);
        @(negedge clk);
        bus.start = 1'b0;
        bus.len   = 5'd0;
        check("busy_after_start", bus.busy, 1);
    endtask

    task automatic fill(input int mode, input int val);
        for (int i = 0; i < 64; i++)
            ref_mem[i] = (mode == 0) ? 8'(val) : 8'($urandom_range(0, 255));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int t1;
        n_vec     = 0;
        n_bad     = 0;
        rd_cnt    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.len   = 5'd0;
        fill(0, 0);

        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_rd_en", bus.ref_rd_en, 0);
        check("rst_rd_addr", bus.ref_rd_addr, 0);
        check("rst_pred_valid", bus.pred_valid, 0);
        check("rst_mcm_x", bus.mcm_x, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // len=4, flat 100 -> 95 each
        fill(0, 100);
        start_run(4, 1'b1, 95, t0);
        check("fetch_rd_en", bus.ref_rd_en, 1);
        wait_until(t0 + 14);

        // len=0 means 32 samples, flat 255 -> 243
        fill(0, 255);
        start_run(0, 1'b1, 243, t0);
        wait_until(t0 + 42);

        // Lone 255 on tap 3: negative sum -> clipped to 0, or wraps to 0xF4
        fill(0, 0);
        ref_mem[2] = 8'd255;
`ifdef MCM_FILTER_CLIP_EN
        start_run(1, 1'b1, 0, t0);
`else
        start_run(1, 1'b1, 244, t0);
`endif
        wait_until(t0 + 10);

        // Start re-pulsed mid-run with another length must be ignored
        fill(1, 0);
        start_run(8, 1'b0, 0, t0);
        wait_until(t0 + 3);
        bus.start = 1'b1;
        bus.len   = 5'd3;
        @(negedge clk);
        bus.start = 1'b0;
        bus.len   = 5'd0;
        wait_until(t0 + 24);

        // Reset in cycle 7 aborts the run; pred[0], pred[1] were already out
        fill(1, 0);
        start_run(8, 1'b0, 0, t0);
        wait_until(t0 + 7);
        rst = 1'b1;
        #2;
        exp_q.delete();
        done_q.delete();
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_rd_en", bus.ref_rd_en, 0);
        check("abort_rd_addr", bus.ref_rd_addr, 0);
        check("abort_pred_valid", bus.pred_valid, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        fill(1, 0);
        start_run(5, 1'b0, 0, t0);
        wait_until(t0 + 16);

        // Back-to-back: second start in the cycle right after done
        fill(1, 0);
        start_run(6, 1'b0, 0, t0);
        wait_until(t0 + 13);
        start_run(6, 1'b0, 0, t1);
        check("b2b_spacing", t1 - t0, 13);
        wait_until(t1 + 20);

        check("exp_left", exp_q.size(), 0);
        check("done_left", done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
